// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word layout, opcodes and pipeline stage record for the
// decode -> execute control path.
package cpu_ctrl_pkg;

  localparam int CW = 10;
  localparam int RW = 4;

  localparam int ALU_SRC   = 0;
  localparam int ALUOP_LSB = 1;
  localparam int MEM_WR    = 5;
  localparam int MEM2REG   = 6;
  localparam int REG_WR    = 7;
  localparam int MEM_RD    = 8;
  localparam int BANK      = 9;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b1011;

  localparam logic [CW-1:0] BUBBLE = 10'h000;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rd;
  } stage_t;

  localparam stage_t BUBBLE_STAGE = {BUBBLE, 4'h0};

  typedef enum logic {
    LAT_MUL = 1'b0,
    LAT_DIV = 1'b1
  } lat_sel_e;

  function automatic logic [3:0] aluop_of(input logic [CW-1:0] c);
    return c[ALUOP_LSB +: 4];
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the decode-stage control unit (master) and the
// control pipeline (slave).
interface ctrl_pipe_if;
  import cpu_ctrl_pkg::*;

  // Handshake: stall_n is the ready for the ID word. The word on c_dec_in/id_*
  // is consumed on a rising edge where stall_n=1; while stall_n=0 the master
  // must re-present the same word unchanged. There is no separate valid, an
  // idle slot is presented as BUBBLE.
  logic [CW-1:0] c_dec_in;
  logic          flush_ir;
  logic [RW-1:0] id_rd;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_use;
  logic          id_rs2_use;

  logic [3:0]    aluop_cdec;
  logic          ex_alu_src;
  logic [RW-1:0] ex_rd;
  logic          mem_wr;
  logic          mem_rd;
  logic [RW-1:0] mem_rd_idx;
  logic          wb_reg_wr;
  logic          wb_mem2reg;
  logic          wb_bank;
  logic [RW-1:0] wb_rd;
  logic          stall_n;
  logic          mdu_busy;

  modport master (
    output c_dec_in, flush_ir, id_rd, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
    input  aluop_cdec, ex_alu_src, ex_rd, mem_wr, mem_rd, mem_rd_idx,
           wb_reg_wr, wb_mem2reg, wb_bank, wb_rd, stall_n, mdu_busy
  );

  modport slave (
    input  c_dec_in, flush_ir, id_rd, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
    output aluop_cdec, ex_alu_src, ex_rd, mem_wr, mem_rd, mem_rd_idx,
           wb_reg_wr, wb_mem2reg, wb_bank, wb_rd, stall_n, mdu_busy
  );

endinterface

// File: rtl/ctrl_pipe_mdu_stall_counter.sv
// Counts the extra EX cycles a mul/div occupies; busy while any remain.
module mdu_stall_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  lat_sel_e lat_sel,
  input  logic     dec,
  output logic     busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] cnt;

  // A latency of 1 loads zero, so such an op never raises busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (lat_sel == LAT_DIV) ? DIV_INIT : MUL_INIT;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with bubble insertion for branch
// flush, load-use hazards and multi-cycle mul/div occupancy of EX.
module ctrl_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic      clk,
  input  logic      rst,
  ctrl_pipe_if.slave bus
);

  stage_t   ex_q, mem_q, wb_q;
  stage_t   ex_d, mem_d;
  logic     mdu_busy;
  logic     lu_hz;
  logic     rs1_hit, rs2_hit;
  logic     cnt_load;
  lat_sel_e cnt_sel;
  logic [3:0] id_aluop;

  assign id_aluop = aluop_of(bus.c_dec_in);

  // ex_q.rd != 0 keeps r0 from ever being a hazard source.
  assign rs1_hit = bus.id_rs1_use && (ex_q.rd == bus.id_rs1);
  assign rs2_hit = bus.id_rs2_use && (ex_q.rd == bus.id_rs2);
  assign lu_hz   = ex_q.ctrl[MEM_RD] && (ex_q.rd != '0) && (rs1_hit || rs2_hit);

  always_comb begin
    ex_d     = ex_q;
    mem_d    = ex_q;
    cnt_load = 1'b0;
    cnt_sel  = (id_aluop == OP_DIV) ? LAT_DIV : LAT_MUL;
    if (mdu_busy) begin
      mem_d = BUBBLE_STAGE;
    end else if (lu_hz || bus.flush_ir) begin
      // On a load-use stall the ID word re-presents, so any flush is moot.
      ex_d = BUBBLE_STAGE;
    end else begin
      ex_d     = '{ctrl: bus.c_dec_in, rd: bus.id_rd};
      cnt_load = (id_aluop == OP_MUL) || (id_aluop == OP_DIV);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= BUBBLE_STAGE;
      mem_q <= BUBBLE_STAGE;
      wb_q  <= BUBBLE_STAGE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
    end
  end

  mdu_stall_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .lat_sel (cnt_sel),
    .dec     (mdu_busy),
    .busy    (mdu_busy)
  );

  assign bus.aluop_cdec = aluop_of(ex_q.ctrl);
  assign bus.ex_alu_src = ex_q.ctrl[ALU_SRC];
  assign bus.ex_rd      = ex_q.rd;
  assign bus.mem_wr     = mem_q.ctrl[MEM_WR];
  assign bus.mem_rd     = mem_q.ctrl[MEM_RD];
  assign bus.mem_rd_idx = mem_q.rd;
  assign bus.wb_reg_wr  = wb_q.ctrl[REG_WR];
  assign bus.wb_mem2reg = wb_q.ctrl[MEM2REG];
  assign bus.wb_bank    = wb_q.ctrl[BANK];
  assign bus.wb_rd      = wb_q.rd;
  assign bus.stall_n    = !(mdu_busy || lu_hz);
  assign bus.mdu_busy   = mdu_busy;

  // EX/MEM-only fields are carried into WB but have no consumer there.
  logic unused_wb;
  assign unused_wb = ^{wb_q.ctrl[MEM_RD], wb_q.ctrl[MEM_WR:ALU_SRC]};

endmodule
